// File: rtl/io_axi_serial_bridge.sv
// io_axi_serial_bridge: AXI4 responder for the fcpu io_* port.
// Write beats become a byte TX stream. RX bytes come back as R beats.
// One status address reports {rx_valid, !tx_valid} without consuming anything.
module io_axi_serial_bridge #(
   parameter int unsigned       ID_W        = 4,
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] STATUS_ADDR = 'h4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [ID_W-1:0]   s_awid,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic [7:0]        s_awlen,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [7:0]        s_wdata,
   input  logic              s_wlast,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [ID_W-1:0]   s_bid,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ID_W-1:0]   s_arid,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic [7:0]        s_arlen,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [ID_W-1:0]   s_rid,
   output logic [7:0]        s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rlast,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

   // ---------------- write side ----------------
   wstate_t          r_wstate, w_wstate_nxt;
   logic             r_awready;
   logic [ID_W-1:0]  r_awid;
   logic [7:0]       r_awlen, r_wcnt;
   logic             r_wstat;
   logic [1:0]       r_bresp;
   logic             r_tx_valid;
   logic [7:0]       r_tx_data;

   logic w_aw_hs, w_wready, w_wbeat, w_wcnt_end, w_wend;

   assign w_aw_hs    = s_awvalid & r_awready;
   assign w_wready   = (r_wstate == W_DATA) & (~r_tx_valid | tx_ready);
   assign w_wbeat    = s_wvalid & w_wready;
   assign w_wcnt_end = (r_wcnt == r_awlen);
   assign w_wend     = w_wbeat & (s_wlast | w_wcnt_end);

   // Write FSM state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_wstate <= W_IDLE;
      else       r_wstate <= w_wstate_nxt;
   end

   // Write FSM next-state: burst ends on wlast or on the awlen-th beat, whichever comes first
   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_aw_hs)  w_wstate_nxt = W_DATA;
         W_DATA:  if (w_wend)   w_wstate_nxt = W_RESP;
         W_RESP:  if (s_bready) w_wstate_nxt = W_IDLE;
         default:               w_wstate_nxt = W_IDLE;
      endcase
   end

   // Write address latch, beat counter, response code and the single-byte TX holding register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_awready  <= 1'b0;
         r_awid     <= '0;
         r_awlen    <= '0;
         r_wcnt     <= '0;
         r_wstat    <= 1'b0;
         r_bresp    <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_awready <= (w_wstate_nxt == W_IDLE);
         if (w_aw_hs) begin
            r_awid  <= s_awid;
            r_awlen <= s_awlen;
            r_wstat <= (s_awaddr == STATUS_ADDR);
            r_wcnt  <= '0;
         end else if (w_wbeat && !w_wcnt_end) begin
            r_wcnt <= r_wcnt + 8'd1;
         end
         if (w_wend)
            r_bresp <= (s_wlast && w_wcnt_end) ? 2'b00 : 2'b10;
         if (w_wbeat && !r_wstat) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= s_wdata;
         end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
         end
      end
   end

   assign s_awready = r_awready;
   assign s_wready  = w_wready;
   assign s_bvalid  = (r_wstate == W_RESP);
   assign s_bid     = r_awid;
   assign s_bresp   = r_bresp;
   assign tx_valid  = r_tx_valid;
   assign tx_data   = r_tx_data;

   // ---------------- read side ----------------
   rstate_t          r_rstate, w_rstate_nxt;
   logic             r_arready;
   logic [ID_W-1:0]  r_arid;
   logic [7:0]       r_arlen, r_rcnt;
   logic             r_rstat;
   logic             r_rvalid, r_rlast;
   logic [7:0]       r_rdata;

   logic w_ar_hs, w_rslot, w_rload, w_rcnt_end;

   assign w_ar_hs    = s_arvalid & r_arready;
   // Slot is free when nothing is pending or it drains this cycle; once the last
   // beat is loaded no further bytes may be pulled from RX.
   assign w_rslot    = (r_rstate == R_DATA) & ~(r_rvalid & r_rlast) & (~r_rvalid | s_rready);
   assign w_rload    = w_rslot & (r_rstat | rx_valid);
   assign w_rcnt_end = (r_rcnt == r_arlen);

   // Read FSM state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_rstate <= R_IDLE;
      else       r_rstate <= w_rstate_nxt;
   end

   // Read FSM next-state: return to idle once the last beat is taken
   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
         R_DATA:  if (r_rvalid && r_rlast && s_rready) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // Read address latch, beat counter and R output register (stable until rready)
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_arready <= 1'b0;
         r_arid    <= '0;
         r_arlen   <= '0;
         r_rcnt    <= '0;
         r_rstat   <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_arready <= (w_rstate_nxt == R_IDLE);
         if (w_ar_hs) begin
            r_arid  <= s_arid;
            r_arlen <= s_arlen;
            r_rstat <= (s_araddr == STATUS_ADDR);
            r_rcnt  <= '0;
         end else if (w_rload && !w_rcnt_end) begin
            r_rcnt <= r_rcnt + 8'd1;
         end
         if (w_rload) begin
            r_rvalid <= 1'b1;
            r_rlast  <= w_rcnt_end;
            r_rdata  <= r_rstat ? {6'b0, rx_valid, ~r_tx_valid} : rx_data;
         end else if (s_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

   assign s_arready = r_arready;
   assign s_rvalid  = r_rvalid;
   assign s_rlast   = r_rlast;
   assign s_rdata   = r_rdata;
   assign s_rid     = r_arid;
   assign s_rresp   = 2'b00;
   assign rx_ready  = w_rslot & ~r_rstat;

endmodule

// File: tb/tb_io_axi_serial_bridge.sv
// Self-checking bench for io_axi_serial_bridge: directed steps with scoreboard queues.
module tb_io_axi_serial_bridge;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 32;
   localparam logic [31:0] STAT   = 32'h4;

   logic              clk, nrst;
   logic [ID_W-1:0]   s_awid, s_bid, s_arid, s_rid;
   logic [ADDR_W-1:0] s_awaddr, s_araddr;
   logic [7:0]        s_awlen, s_arlen, s_wdata, s_rdata, tx_data, rx_data;
   logic              s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
   logic [1:0]        s_bresp, s_rresp;
   logic              s_bvalid, s_bready, s_arvalid, s_arready;
   logic              s_rlast, s_rvalid, s_rready;
   logic              tx_valid, tx_ready, rx_valid, rx_ready;

   io_axi_serial_bridge #(.ID_W(ID_W), .ADDR_W(ADDR_W), .STATUS_ADDR(STAT)) dut (
      .clk(clk), .nrst(nrst),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  txq[$];    // expected TX bytes
   logic [5:0]  bq[$];     // expected {bid, bresp}
   logic [14:0] rq[$];     // expected {rid, rdata, rlast, rresp}
   logic [7:0]  rxsrc[$];  // bytes offered on the RX side
   int          tx_mode = 0;  // 0 low, 1 high, 2 toggle
   logic        stat_watch = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // tx_ready driver
   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (tx_mode)
            1:       tx_ready = 1'b1;
            2:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // RX byte source: present head of rxsrc, pop when the DUT takes it
   initial begin
      logic taken;
      rx_valid = 1'b0;
      rx_data  = '0;
      forever begin
         @(negedge clk);
         taken = rx_valid && rx_ready && nrst;
         @(posedge clk); #1;
         if (taken && rxsrc.size() > 0) void'(rxsrc.pop_front());
         rx_valid = (rxsrc.size() > 0);
         rx_data  = (rxsrc.size() > 0) ? rxsrc[0] : 8'h00;
      end
   end

   // Output monitor: every handshake is checked against the scoreboard
   always @(negedge clk) begin
      if (nrst) begin
         if (tx_valid && tx_ready)
            chk("tx_byte", {1'b1, tx_data}, (txq.size() > 0) ? {1'b1, txq.pop_front()} : 9'h0);
         if (tx_valid && !tx_ready)
            chk("wready_stall", s_wready, 0);
         if (s_bvalid && s_bready)
            chk("b_resp", {1'b1, s_bid, s_bresp}, (bq.size() > 0) ? {1'b1, bq.pop_front()} : 7'h0);
         if (s_rvalid && s_rready)
            chk("r_beat", {1'b1, s_rid, s_rdata, s_rlast, s_rresp},
                (rq.size() > 0) ? {1'b1, rq.pop_front()} : 16'h0);
         if (stat_watch)
            chk("rx_ready_stat", rx_ready, 0);
      end
   end

   task automatic do_aw(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
      bit ok = 0;
      s_awid = id; s_awlen = len; s_awaddr = addr; s_awvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (s_awready) begin ok = 1; break; end
      end
      chk("aw_accept", ok, 1);
      @(posedge clk); #1;
      s_awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [7:0] d, input logic last);
      bit ok = 0;
      s_wdata = d; s_wlast = last; s_wvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (s_wready) begin ok = 1; break; end
      end
      chk("w_accept", ok, 1);
      @(posedge clk); #1;
      s_wvalid = 1'b0; s_wlast = 1'b0;
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
      bit ok = 0;
      s_arid = id; s_arlen = len; s_araddr = addr; s_arvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (s_arready) begin ok = 1; break; end
      end
      chk("ar_accept", ok, 1);
      @(posedge clk); #1;
      s_arvalid = 1'b0;
   endtask

   task automatic drain(input int n);
      bit ok = 0;
      for (int i = 0; i < n; i++) begin
         if (txq.size() == 0 && bq.size() == 0 && rq.size() == 0) begin ok = 1; break; end
         tick();
      end
      chk("drain", ok, 1);
      tick(2);
   endtask

   function automatic logic [63:0] all_outs();
      return {s_awready, s_wready, s_bvalid, s_bid, s_bresp, s_arready, s_rvalid, s_rid,
              s_rdata, s_rresp, s_rlast, tx_valid, tx_data, rx_ready};
   endfunction

   initial begin
      bit ok;
      nrst = 1'b0;
      s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
      s_wdata = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
      s_arid = '0; s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; s_rready = 1'b1;
      #1 chk("reset_outs", all_outs(), 0);
      tick(3);
      nrst = 1'b1;
      chk("ready_before_edge", {s_awready, s_arready}, 2'b00);
      tick();
      chk("ready_after_release", {s_awready, s_arready}, 2'b11);

      // single-byte write, B held until bready
      tx_mode = 1; s_bready = 1'b0;
      txq.push_back(8'h41); bq.push_back({4'd3, 2'b00});
      do_aw(4'd3, 8'd0, 32'h0);
      do_w(8'h41, 1'b1);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (s_bvalid) begin ok = 1; break; end
         tick();
      end
      chk("bvalid_seen", ok, 1);
      tick(3);
      chk("b_hold", {s_bvalid, s_bid, s_bresp}, {1'b1, 4'd3, 2'b00});
      s_bready = 1'b1;
      drain(40);

      // 4-beat burst with tx_ready toggling
      tx_mode = 2;
      for (int i = 0; i < 4; i++) txq.push_back(8'h10 + 8'(i));
      bq.push_back({4'd7, 2'b00});
      do_aw(4'd7, 8'd3, 32'h0);
      for (int i = 0; i < 4; i++) do_w(8'h10 + 8'(i), i == 3);
      drain(60);

      // early wlast -> SLVERR, then a normal burst, then len-end without wlast
      tx_mode = 1;
      txq.push_back(8'h20); txq.push_back(8'h21); bq.push_back({4'd2, 2'b10});
      do_aw(4'd2, 8'd3, 32'h0);
      do_w(8'h20, 1'b0); do_w(8'h21, 1'b1);
      drain(40);
      txq.push_back(8'h30); txq.push_back(8'h31); bq.push_back({4'd4, 2'b00});
      do_aw(4'd4, 8'd1, 32'h0);
      do_w(8'h30, 1'b0); do_w(8'h31, 1'b1);
      drain(40);
      txq.push_back(8'h40); bq.push_back({4'd6, 2'b10});
      do_aw(4'd6, 8'd0, 32'h0);
      do_w(8'h40, 1'b0);
      drain(40);

      // write to status address: byte dropped, B OKAY
      bq.push_back({4'd1, 2'b00});
      do_aw(4'd1, 8'd0, STAT);
      do_w(8'hEE, 1'b1);
      drain(40);

      // 2-beat data read, RX bytes arrive late
      rq.push_back({4'd5, 8'h55, 1'b0, 2'b00});
      rq.push_back({4'd5, 8'hAA, 1'b1, 2'b00});
      do_ar(4'd5, 8'd1, 32'h0);
      tick(20);
      rxsrc.push_back(8'h55); rxsrc.push_back(8'hAA);
      drain(60);

      // status read: rx has a byte, tx idle -> 0x03, byte not consumed
      rxsrc.push_back(8'h77);
      tick(3);
      stat_watch = 1'b1;
      rq.push_back({4'd9, 8'h03, 1'b1, 2'b00});
      do_ar(4'd9, 8'd0, STAT);
      drain(40);
      stat_watch = 1'b0;
      chk("rx_not_popped", rxsrc.size(), 1);

      // reset in the middle of a write burst and a read burst
      s_rready = 1'b0; tx_mode = 0;
      do_ar(4'd10, 8'd1, 32'h0);
      do_aw(4'd11, 8'd3, 32'h0);
      do_w(8'h61, 1'b0);
      s_wdata = 8'h62; s_wvalid = 1'b1;
      tick(2);
      chk("mid_read", {s_rvalid, s_rlast, s_rdata}, {1'b1, 1'b0, 8'h77});
      chk("mid_write", {tx_valid, tx_data, s_wready}, {1'b1, 8'h61, 1'b0});
      nrst = 1'b0; s_wvalid = 1'b0;
      #1 chk("reset_mid_outs", all_outs(), 0);
      txq.delete(); bq.delete(); rq.delete();
      tick(2);
      nrst = 1'b1;
      tick();
      chk("ready_after_rereset", {s_awready, s_arready}, 2'b11);
      s_rready = 1'b1; tx_mode = 1;
      txq.push_back(8'h5A); bq.push_back({4'd12, 2'b00});
      do_aw(4'd12, 8'd0, 32'h0);
      do_w(8'h5A, 1'b1);
      rq.push_back({4'd13, 8'h99, 1'b1, 2'b00});
      rxsrc.push_back(8'h99);
      do_ar(4'd13, 8'd0, 32'h0);
      drain(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
